// File: rtl/pppc_share_arbiter_if.sv
// Request/bounds/flip bundle between two requesters, the share arbiter and the
// single ping-pong counter it drives.
interface pppc_share_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] min0;
  logic [WIDTH-1:0] max0;
  logic [WIDTH-1:0] min1;
  logic [WIDTH-1:0] max1;
  logic [1:0]       flip_req;
  logic             cnt_direction;
  logic             cnt_enable;
  logic             cnt_flip;
  logic [WIDTH-1:0] cnt_min;
  logic [WIDTH-1:0] cnt_max;
  logic [1:0]       grant;
  logic             slice_done;
  logic             cfg_err;

  modport slave (
    input  req, min0, max0, min1, max1, flip_req, cnt_direction,
    output cnt_enable, cnt_flip, cnt_min, cnt_max, grant, slice_done, cfg_err
  );

  modport master (
    output req, min0, max0, min1, max1, flip_req, cnt_direction,
    input  cnt_enable, cnt_flip, cnt_min, cnt_max, grant, slice_done, cfg_err
  );
endinterface

// File: rtl/pppc_share_arbiter.sv
// Round-robin owner of one ping-pong counter; a grant lasts SLICE_BOUNCES natural
// direction reversals or until the owner lets go of its request.
module pppc_share_arbiter #(
  parameter int WIDTH         = 4,
  parameter int SLICE_BOUNCES = 2
) (
  input logic                clk,
  input logic                rst,
  pppc_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [3:0] SLICE_LIMIT = 4'(SLICE_BOUNCES);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [3:0]       bounce_q, bounce_d;
  logic             dir_q, dir_d;
  logic [1:0]       flip_prev_q, flip_prev_d;
  logic             flip_dly_q, flip_dly_d;
  logic             cnt_enable_q, cnt_enable_d;
  logic             cnt_flip_q, cnt_flip_d;
  logic [WIDTH-1:0] cnt_min_q, cnt_min_d;
  logic [WIDTH-1:0] cnt_max_q, cnt_max_d;
  logic [1:0]       grant_q, grant_d;
  logic             slice_done_q, slice_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             counted;
  logic [3:0]       bounce_inc;
  logic             owner_req;
  logic             flip_edge;

  // A reversal seen one cycle after our own flip pulse was caused by that flip.
  assign counted    = (bus.cnt_direction != dir_q) && !flip_dly_q;
  assign bounce_inc = bounce_q + {3'b000, counted};
  assign owner_req  = bus.req[owner_q];
  assign flip_edge  = bus.flip_req[owner_q] & ~flip_prev_q[owner_q];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    bounce_d    = bounce_q;
    dir_d       = bus.cnt_direction;
    flip_prev_d = bus.flip_req;
    flip_dly_d  = cnt_flip_q;
    cnt_min_d   = cnt_min_q;
    cnt_max_d   = cnt_max_q;
    cnt_flip_d  = 1'b0;
    cfg_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          if (bus.req == 2'b11) begin
            owner_d = ~last_q;
          end else begin
            owner_d = bus.req[1];
          end
          if (owner_d) begin
            cnt_min_d = bus.min1;
            cnt_max_d = bus.max1;
          end else begin
            cnt_min_d = bus.min0;
            cnt_max_d = bus.max0;
          end
          cfg_err_d = (cnt_min_d >= cnt_max_d);
          state_d   = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        bounce_d = 4'd0;
        if (cnt_min_q >= cnt_max_q) begin
          state_d = RELEASE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        bounce_d = bounce_inc;
        if ((bounce_inc == SLICE_LIMIT) || !owner_req) begin
          state_d = RELEASE;
        end else begin
          state_d    = RUN;
          cnt_flip_d = flip_edge;
        end
      end
      RELEASE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are the Moore view of the state being entered, so they register cleanly.
    cnt_enable_d = (state_d == RUN);
    slice_done_d = (state_d == RELEASE);
    if ((state_d == LOAD) || (state_d == RUN)) begin
      grant_d = owner_d ? 2'b10 : 2'b01;
    end else begin
      grant_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      bounce_q     <= 4'd0;
      dir_q        <= 1'b0;
      flip_prev_q  <= 2'b00;
      flip_dly_q   <= 1'b0;
      cnt_enable_q <= 1'b0;
      cnt_flip_q   <= 1'b0;
      cnt_min_q    <= {WIDTH{1'b0}};
      cnt_max_q    <= {WIDTH{1'b1}};
      grant_q      <= 2'b00;
      slice_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      bounce_q     <= bounce_d;
      dir_q        <= dir_d;
      flip_prev_q  <= flip_prev_d;
      flip_dly_q   <= flip_dly_d;
      cnt_enable_q <= cnt_enable_d;
      cnt_flip_q   <= cnt_flip_d;
      cnt_min_q    <= cnt_min_d;
      cnt_max_q    <= cnt_max_d;
      grant_q      <= grant_d;
      slice_done_q <= slice_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bus.cnt_enable = cnt_enable_q;
  assign bus.cnt_flip   = cnt_flip_q;
  assign bus.cnt_min    = cnt_min_q;
  assign bus.cnt_max    = cnt_max_q;
  assign bus.grant      = grant_q;
  assign bus.slice_done = slice_done_q;
  assign bus.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_pppc_share_arbiter.sv
// Bench for pppc_share_arbiter: directed scenarios plus randomized slices
// checked against a slice-level model of ownership, bounds and slice length.
module tb_pppc_share_arbiter;
  localparam int WIDTH = 4;
  localparam int SLICE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cdir;
  logic nat_rev = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   last_owner = 1;

  pppc_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  pppc_share_arbiter #(.WIDTH(WIDTH), .SLICE_BOUNCES(SLICE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Counter stand-in: direction turns on its own flip or when the bench injects a bounce.
  always @(posedge clk) begin
    if (rst) cdir <= 1'b0;
    else if (bus.cnt_enable && (bus.cnt_flip || nat_rev)) cdir <= ~cdir;
  end
  assign bus.cnt_direction = cdir;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reverse_once();
    nat_rev = 1'b1;
    tick();
    nat_rev = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 2'b00; bus.flip_req = 2'b00;
    bus.min0 = 4'd0; bus.max0 = 4'd15; bus.min1 = 4'd0; bus.max1 = 4'd15;
    tick(); tick();
    rst = 1'b0;
    last_owner = 1;
  endtask

  task automatic wait_grant(output int cycles);
    cycles = 0;
    while (bus.grant == 2'b00 && cycles < 10) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; bus.req = 2'b11;
    tick();
    n_cmp++; if (bus.cnt_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got=%b exp=0", bus.cnt_enable); end
    n_cmp++; if (bus.cnt_flip !== 1'b0) begin n_fail++; $display("FAIL reset_flip got=%b exp=0", bus.cnt_flip); end
    n_cmp++; if (bus.cnt_min !== 4'd0) begin n_fail++; $display("FAIL reset_min got=%0d exp=0", bus.cnt_min); end
    n_cmp++; if (bus.cnt_max !== 4'd15) begin n_fail++; $display("FAIL reset_max got=%0d exp=15", bus.cnt_max); end
    n_cmp++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got=%b exp=00", bus.grant); end
    n_cmp++; if (bus.slice_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.slice_done); end
    n_cmp++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got=%b exp=0", bus.cfg_err); end
    bus.req = 2'b00; rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    bus.min0 = 4'd2; bus.max0 = 4'd5; bus.req = 2'b01;
    tick();
    n_cmp++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL basic_grant got=%b exp=01", bus.grant); end
    n_cmp++; if (bus.cnt_min !== 4'd2 || bus.cnt_max !== 4'd5) begin n_fail++; $display("FAIL basic_bounds got=%0d/%0d exp=2/5", bus.cnt_min, bus.cnt_max); end
    n_cmp++; if (bus.cnt_enable !== 1'b0) begin n_fail++; $display("FAIL basic_load_enable got=%b exp=0", bus.cnt_enable); end
    tick();
    n_cmp++; if (bus.cnt_enable !== 1'b1) begin n_fail++; $display("FAIL basic_run_enable got=%b exp=1", bus.cnt_enable); end
    reverse_once(); tick();
    n_cmp++; if (bus.slice_done !== 1'b0 || bus.grant !== 2'b01) begin n_fail++; $display("FAIL basic_one_bounce done=%b grant=%b exp=0/01", bus.slice_done, bus.grant); end
    reverse_once(); tick();
    n_cmp++; if (bus.slice_done !== 1'b1 || bus.grant !== 2'b00 || bus.cnt_enable !== 1'b0) begin n_fail++; $display("FAIL basic_release done=%b grant=%b en=%b exp=1/00/0", bus.slice_done, bus.grant, bus.cnt_enable); end
    bus.req = 2'b00;
    tick();
    n_cmp++; if (bus.slice_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", bus.slice_done); end
  endtask

  task automatic test_alternate();
    int cyc;
    int exp_owner;
    do_reset();
    bus.min0 = 4'd0; bus.max0 = 4'd15; bus.min1 = 4'd3; bus.max1 = 4'd9; bus.req = 2'b11;
    for (int s = 0; s < 3; s++) begin
      exp_owner = (last_owner == 0) ? 1 : 0;
      wait_grant(cyc);
      n_cmp++; if (cyc != ((s == 0) ? 1 : 2)) begin n_fail++; $display("FAIL alt_latency slice=%0d got=%0d exp=%0d", s, cyc, (s == 0) ? 1 : 2); end
      n_cmp++; if (bus.grant !== ((exp_owner == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_grant slice=%0d got=%b exp_owner=%0d", s, bus.grant, exp_owner); end
      n_cmp++; if (bus.cnt_min !== ((exp_owner == 1) ? 4'd3 : 4'd0) || bus.cnt_max !== ((exp_owner == 1) ? 4'd9 : 4'd15)) begin n_fail++; $display("FAIL alt_bounds slice=%0d got=%0d/%0d", s, bus.cnt_min, bus.cnt_max); end
      tick();
      reverse_once(); reverse_once(); tick();
      n_cmp++; if (bus.slice_done !== 1'b1) begin n_fail++; $display("FAIL alt_done slice=%0d got=%b exp=1", s, bus.slice_done); end
      last_owner = exp_owner;
    end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_flip();
    int flips;
    int dones;
    do_reset();
    bus.min0 = 4'd2; bus.max0 = 4'd5; bus.req = 2'b01;
    tick(); tick();
    flips = 0; dones = 0;
    bus.flip_req = 2'b01;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) bus.flip_req = 2'b10;
      if (i == 5) bus.flip_req = 2'b00;
      tick();
      if (bus.cnt_flip === 1'b1) flips++;
      if (bus.slice_done === 1'b1) dones++;
    end
    n_cmp++; if (flips != 1) begin n_fail++; $display("FAIL flip_pulses got=%0d exp=1", flips); end
    n_cmp++; if (dones != 0 || bus.grant !== 2'b01) begin n_fail++; $display("FAIL flip_not_counted done=%0d grant=%b exp=0/01", dones, bus.grant); end
    reverse_once(); tick();
    n_cmp++; if (bus.slice_done !== 1'b0) begin n_fail++; $display("FAIL flip_first_natural got=%b exp=0", bus.slice_done); end
    reverse_once(); tick();
    n_cmp++; if (bus.slice_done !== 1'b1) begin n_fail++; $display("FAIL flip_second_natural got=%b exp=1", bus.slice_done); end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_cfg_err();
    logic [WIDTH-1:0] bad_min [2];
    bad_min[0] = 4'd9; bad_min[1] = 4'd7;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.min1 = bad_min[i]; bus.max1 = 4'd7; bus.req = 2'b10;
      tick();
      n_cmp++; if (bus.grant !== 2'b10 || bus.cfg_err !== 1'b1 || bus.cnt_enable !== 1'b0) begin n_fail++; $display("FAIL cfg_load case=%0d grant=%b err=%b en=%b exp=10/1/0", i, bus.grant, bus.cfg_err, bus.cnt_enable); end
      tick();
      n_cmp++; if (bus.slice_done !== 1'b1 || bus.cfg_err !== 1'b0 || bus.cnt_enable !== 1'b0 || bus.grant !== 2'b00) begin n_fail++; $display("FAIL cfg_release case=%0d done=%b err=%b en=%b grant=%b", i, bus.slice_done, bus.cfg_err, bus.cnt_enable, bus.grant); end
      bus.req = 2'b00;
      tick();
    end
  endtask

  task automatic test_drop();
    do_reset();
    bus.min0 = 4'd2; bus.max0 = 4'd5; bus.req = 2'b01;
    tick(); tick();
    bus.min0 = 4'd9;
    tick();
    n_cmp++; if (bus.cnt_min !== 4'd2) begin n_fail++; $display("FAIL drop_isolation got=%0d exp=2", bus.cnt_min); end
    reverse_once(); tick();
    n_cmp++; if (bus.slice_done !== 1'b0) begin n_fail++; $display("FAIL drop_early_done got=%b exp=0", bus.slice_done); end
    bus.req = 2'b00;
    tick();
    n_cmp++; if (bus.slice_done !== 1'b1 || bus.grant !== 2'b00) begin n_fail++; $display("FAIL drop_release done=%b grant=%b exp=1/00", bus.slice_done, bus.grant); end
    tick();
    n_cmp++; if (bus.slice_done !== 1'b0 || bus.cnt_min !== 4'd2) begin n_fail++; $display("FAIL drop_after done=%b min=%0d exp=0/2", bus.slice_done, bus.cnt_min); end
    bus.min0 = 4'd2; bus.req = 2'b01;
    tick(); tick();
    reverse_once(); reverse_once();
    bus.req = 2'b00;
    tick();
    n_cmp++; if (bus.slice_done !== 1'b1) begin n_fail++; $display("FAIL drop_simul_release got=%b exp=1", bus.slice_done); end
    tick();
    n_cmp++; if (bus.slice_done !== 1'b0) begin n_fail++; $display("FAIL drop_simul_single got=%b exp=0", bus.slice_done); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    bus.min0 = 4'd2; bus.max0 = 4'd5; bus.req = 2'b01;
    tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.cnt_enable !== 1'b0 || bus.grant !== 2'b00 || bus.slice_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl en=%b grant=%b done=%b exp=0/00/0", bus.cnt_enable, bus.grant, bus.slice_done); end
    n_cmp++; if (bus.cnt_min !== 4'd0 || bus.cnt_max !== 4'd15 || bus.cfg_err !== 1'b0 || bus.cnt_flip !== 1'b0) begin n_fail++; $display("FAIL rstmid_vals min=%0d max=%0d err=%b flip=%b", bus.cnt_min, bus.cnt_max, bus.cfg_err, bus.cnt_flip); end
    rst = 1'b0; bus.req = 2'b11; bus.min1 = 4'd1; bus.max1 = 4'd4;
    tick();
    n_cmp++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL rstmid_first_owner got=%b exp=01", bus.grant); end
    bus.req = 2'b00;
    tick(); tick(); tick();
  endtask

  task automatic test_random();
    int pat, owner, drop_at, nrev, gap;
    logic [WIDTH-1:0] mn, mx;
    logic fr;
    bit done;
    do_reset();
    for (int s = 0; s < 16; s++) begin
      pat = $urandom_range(1, 3);
      owner = (pat == 1) ? 0 : (pat == 2) ? 1 : ((last_owner == 0) ? 1 : 0);
      mn = 4'($urandom_range(0, 15));
      mx = ($urandom_range(0, 4) == 0) ? mn : 4'($urandom_range(0, 15));
      if (owner == 0) begin bus.min0 = mn; bus.max0 = mx; bus.min1 = 4'($urandom_range(0, 15)); bus.max1 = 4'($urandom_range(0, 15)); end
      else begin bus.min1 = mn; bus.max1 = mx; bus.min0 = 4'($urandom_range(0, 15)); bus.max0 = 4'($urandom_range(0, 15)); end
      bus.req = 2'(pat);
      tick();
      n_cmp++; if (bus.grant !== ((owner == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rnd_grant slice=%0d got=%b exp_owner=%0d", s, bus.grant, owner); end
      n_cmp++; if (bus.cnt_min !== mn || bus.cnt_max !== mx) begin n_fail++; $display("FAIL rnd_bounds slice=%0d got=%0d/%0d exp=%0d/%0d", s, bus.cnt_min, bus.cnt_max, mn, mx); end
      n_cmp++; if (bus.cfg_err !== (mn >= mx)) begin n_fail++; $display("FAIL rnd_cfg_err slice=%0d got=%b exp=%b", s, bus.cfg_err, (mn >= mx)); end
      if (mn >= mx) begin
        tick();
        n_cmp++; if (bus.slice_done !== 1'b1 || bus.cnt_enable !== 1'b0) begin n_fail++; $display("FAIL rnd_err_release slice=%0d done=%b en=%b exp=1/0", s, bus.slice_done, bus.cnt_enable); end
      end else begin
        tick();
        n_cmp++; if (bus.cnt_enable !== 1'b1) begin n_fail++; $display("FAIL rnd_enable slice=%0d got=%b exp=1", s, bus.cnt_enable); end
        drop_at = $urandom_range(0, SLICE);
        nrev = 0; done = 1'b0;
        while (!done) begin
          if (nrev == drop_at) begin
            bus.req = 2'b00;
            tick();
            n_cmp++; if (bus.slice_done !== 1'b1) begin n_fail++; $display("FAIL rnd_drop slice=%0d got=%b exp=1", s, bus.slice_done); end
            done = 1'b1;
          end else begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
              fr = 1'($urandom_range(0, 1));
              bus.flip_req = (owner == 0) ? {fr, 1'b0} : {1'b0, fr};
              bus.min0 = 4'($urandom_range(0, 15)); bus.max0 = 4'($urandom_range(0, 15));
              bus.min1 = 4'($urandom_range(0, 15)); bus.max1 = 4'($urandom_range(0, 15));
              tick();
              n_cmp++; if (bus.cnt_flip !== 1'b0 || bus.slice_done !== 1'b0) begin n_fail++; $display("FAIL rnd_gap slice=%0d flip=%b done=%b exp=0/0", s, bus.cnt_flip, bus.slice_done); end
            end
            bus.flip_req = 2'b00;
            reverse_once(); tick();
            nrev++;
            n_cmp++; if (bus.slice_done !== (nrev == SLICE)) begin n_fail++; $display("FAIL rnd_bounce slice=%0d nrev=%0d done=%b", s, nrev, bus.slice_done); end
            if (nrev == SLICE) done = 1'b1;
          end
        end
        n_cmp++; if (bus.cnt_min !== mn || bus.cnt_max !== mx) begin n_fail++; $display("FAIL rnd_held slice=%0d got=%0d/%0d exp=%0d/%0d", s, bus.cnt_min, bus.cnt_max, mn, mx); end
      end
      last_owner = owner;
      bus.req = 2'b00; bus.flip_req = 2'b00;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_flip();
    test_cfg_err();
    test_drop();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
